// File: rtl/mem_rw_pkg.sv
// Shared constants, read-pipeline stage type and parameter legality check
// for the byte-strobed, latency-configurable register memory.
package mem_rw_pkg;

    localparam int RD_LAT_MAX    = 4;
    localparam int BYTE_W        = 8;
    localparam int RD_DATA_W_MAX = 64;

    // Stage data is sized for the widest supported word; narrower words are zero-extended.
    typedef struct packed {
        logic                     valid;
        logic [RD_DATA_W_MAX-1:0] data;
    } rd_stage_t;

    function automatic bit cfg_ok(input int addr_w, input int data_w, input int rd_lat);
        return (addr_w >= 1) &&
               (data_w >= BYTE_W) &&
               ((data_w % BYTE_W) == 0) &&
               (data_w <= RD_DATA_W_MAX) &&
               (rd_lat >= 1) &&
               (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Delay line of {valid, data} read results, DEPTH stages deep, with a
// synchronous flush so in-flight results vanish on reset.
module mem_rd_pipe
    import mem_rw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (DEPTH < 1 || DATA_W > RD_DATA_W_MAX || DATA_W < 1) begin : g_cfg_err
        $error("mem_rd_pipe: illegal parameters DATA_W=%0d DEPTH=%0d", DATA_W, DEPTH);
    end

    rd_stage_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{valid: in_valid, data: RD_DATA_W_MAX'(in_data)};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_data  = stage[DEPTH-1].data[DATA_W-1:0];

endmodule

// File: rtl/mem_rw_pipe.sv
// Word-addressed register memory with byte-strobed writes, a pipelined
// read path of configurable latency, and a read/write collision flag.
module mem_rw_pipe
    import mem_rw_pkg::*;
#(
    parameter int                ADDR_W    = 2,
    parameter int                DATA_W    = 8,
    parameter int                RD_LAT    = 1,
    parameter logic [BYTE_W-1:0] INIT_BYTE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] wstrb,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rd_valid,
    output logic                     err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                STRB_W    = DATA_W / BYTE_W;
    localparam logic [DATA_W-1:0] INIT_WORD = {STRB_W{INIT_BYTE}};

    if (!cfg_ok(ADDR_W, DATA_W, RD_LAT)) begin : g_cfg_err
        $error("mem_rw_pipe: illegal parameters ADDR_W=%0d DATA_W=%0d RD_LAT=%0d",
               ADDR_W, DATA_W, RD_LAT);
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_accept;
    logic              rd_accept;
    logic              collide;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    // A simultaneous read and write cancels both and is only reported.
    assign collide   = wr_en & rd_en;
    assign wr_accept = wr_en & ~rd_en;
    assign rd_accept = rd_en & ~wr_en;
    assign rd_word   = mem[addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= INIT_WORD;
            end
        end else if (wr_accept) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // The final latency cycle is the output register below, so the delay line is one shorter.
    if (RD_LAT > 1) begin : g_pipe
        mem_rd_pipe #(
            .DATA_W (DATA_W),
            .DEPTH  (RD_LAT - 1)
        ) u_rd_pipe (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (rd_accept),
            .in_data   (rd_word),
            .out_valid (pipe_valid),
            .out_data  (pipe_data)
        );
    end else begin : g_direct
        assign pipe_valid = rd_accept;
        assign pipe_data  = rd_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= pipe_valid;
            err      <= collide;
            if (pipe_valid) begin
                rdata <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_rw_pipe.sv
// Self-checking bench for mem_rw_pipe: directed literal cases plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_mem_rw_pipe;

    localparam int          ADDR_W    = 2;
    localparam int          DATA_W    = 16;
    localparam int          RD_LAT    = 3;
    localparam int          STRB_W    = DATA_W / 8;
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [7:0]  INIT_BYTE = 8'hFF;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_rw_pipe #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .INIT_BYTE (INIT_BYTE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .err      (err)
    );

    // Reference model: word array plus a queue of reads tagged with the cycle they complete.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } pend_t;

    pend_t             pend [$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_valid = 1'b0;
    logic              exp_err   = 1'b0;
    int                cyc       = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = {STRB_W{INIT_BYTE}};
                pend.delete();
                exp_rdata = '0;
                exp_valid = 1'b0;
                exp_err   = 1'b0;
            end else begin
                exp_err = wr_en && rd_en;
                if (rd_en && !wr_en) pend.push_back('{due: cyc + RD_LAT - 1, data: model_mem[addr]});
                exp_valid = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    exp_valid = 1'b1;
                    exp_rdata = pend[0].data;
                    void'(pend.pop_front());
                end
                if (wr_en && !rd_en) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb[b]) model_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_rd_valid", 32'(rd_valid), 32'(exp_valid));
            checkOutput("model_err", 32'(err), 32'(exp_err));
            checkOutput("model_rdata", 32'(rdata), 32'(exp_rdata));
        end
    end

    task automatic applyStimulus(input logic rst, input logic w, input logic r,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                 input logic [STRB_W-1:0] s);
        reset = rst;
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(negedge clk);
    endtask

    logic [DATA_W-1:0] preload [4];

    initial begin
        int k;
        preload = '{16'd11, 16'd22, 16'd33, 16'd44};

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_rdata", 32'(rdata), 32'h0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);

        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(0, 0, 1, ADDR_W'(i), 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0);
            if (i >= RD_LAT - 1) begin
                checkOutput("init_rd_valid", 32'(rd_valid), 32'h1);
                checkOutput("init_rdata", 32'(rdata), 32'hFFFF);
            end else begin
                checkOutput("init_no_valid", 32'(rd_valid), 32'h0);
            end
            checkOutput("init_err", 32'(err), 32'h0);
        end

        applyStimulus(0, 1, 0, 1, 16'hA5A5, 2'b11);
        applyStimulus(0, 1, 0, 1, 16'h3C3C, 2'b10);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("strb_not_yet", 32'(rd_valid), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("strb_rd_valid", 32'(rd_valid), 32'h1);
        checkOutput("strb_rdata", 32'(rdata), 32'h3CA5);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, ADDR_W'(i), preload[i], 2'b11);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(0, 0, 1, ADDR_W'(i), 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0);
            if (i >= RD_LAT - 1) begin
                checkOutput("pipe_rd_valid", 32'(rd_valid), 32'h1);
                checkOutput("pipe_rdata", 32'(rdata), 32'(preload[i-(RD_LAT-1)]));
            end else begin
                checkOutput("pipe_no_valid", 32'(rd_valid), 32'h0);
            end
        end

        applyStimulus(0, 1, 0, 2, 16'h0055, 2'b11);
        applyStimulus(0, 0, 1, 2, 0, 0);
        applyStimulus(0, 0, 1, 2, 0, 0);
        applyStimulus(0, 1, 0, 2, 16'h0077, 2'b11);
        checkOutput("raw_rdata", 32'(rdata), 32'h0055);
        checkOutput("raw_rd_valid", 32'(rd_valid), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("war_rdata", 32'(rdata), 32'h0055);
        checkOutput("war_rd_valid", 32'(rd_valid), 32'h1);
        applyStimulus(0, 0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("war_new_rdata", 32'(rdata), 32'h0077);

        applyStimulus(0, 1, 0, 3, 16'h0010, 2'b11);
        applyStimulus(0, 1, 1, 3, 16'h0099, 2'b11);
        checkOutput("coll_err", 32'(err), 32'h1);
        checkOutput("coll_no_valid", 32'(rd_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("coll_err_clear", 32'(err), 32'h0);
            checkOutput("coll_never_valid", 32'(rd_valid), 32'h0);
        end
        applyStimulus(0, 0, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("coll_mem_kept", 32'(rdata), 32'h0010);

        applyStimulus(0, 1, 0, 0, 16'h1234, 2'b11);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("flush_no_valid", 32'(rd_valid), 32'h0);
            checkOutput("flush_rdata", 32'(rdata), 32'h0);
        end
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("flush_mem_init", 32'(rdata), 32'hFFFF);

        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 63);
            if (k < 24)      applyStimulus(0, 1, 0, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
            else if (k < 48) applyStimulus(0, 0, 1, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
            else if (k < 51) applyStimulus(0, 1, 1, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
            else if (k < 53) applyStimulus(1, 0, 0, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
            else             applyStimulus(0, 0, 0, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
        end

        for (int i = 0; i < RD_LAT + 2; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
